// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush sequencer: load-use bubbles, taken-branch flushes and a
// fixed-latency mult/div hold, plus a saturating stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int MD_LAT = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemR_EX,
    input  logic [4:0]  EX_rfWeSel,
    input  logic [4:0]  ID_rfReSel1,
    input  logic [4:0]  ID_rfReSel2,
    input  logic        ID_useRs,
    input  logic        ID_useRt,
    input  logic        ID_MulDiv,
    input  logic        Branch_EX,
    output logic        PC_We,
    output logic        IFID_We,
    output logic        IFID_Flush,
    output logic        IDEX_Flush,
    output logic        MulDiv_Start,
    output logic        MulDiv_Busy,
    output logic        MulDiv_Done,
    output logic [15:0] Stall_Cnt
);

    localparam int CW = $clog2(MD_LAT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        IDLE   = 1'b0,
        MDBUSY = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [15:0]     stall_cnt_reg;
    logic            loaduse;
    logic            rs_hit, rt_hit;

    assign rs_hit  = ID_useRs && (EX_rfWeSel == ID_rfReSel1);
    assign rt_hit  = ID_useRt && (EX_rfWeSel == ID_rfReSel2);
    // Writes to r0 never create a dependency.
    assign loaduse = MemR_EX && (EX_rfWeSel != 5'd0) && (rs_hit || rt_hit);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (!Branch_EX && !loaduse && ID_MulDiv) begin
                    state_next = MDBUSY;
                    cnt_next   = CNT_LOAD;
                end
            end
            MDBUSY: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_ONE;
                end else begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // Outputs stay at their pass-through defaults while Reset is asserted.
    always_comb begin
        PC_We        = 1'b1;
        IFID_We      = 1'b1;
        IFID_Flush   = 1'b0;
        IDEX_Flush   = 1'b0;
        MulDiv_Start = 1'b0;
        MulDiv_Busy  = 1'b0;
        MulDiv_Done  = 1'b0;
        if (!Reset) begin
            case (state_reg)
                IDLE: begin
                    if (Branch_EX) begin
                        IFID_Flush = 1'b1;
                        IDEX_Flush = 1'b1;
                    end else if (loaduse) begin
                        PC_We      = 1'b0;
                        IFID_We    = 1'b0;
                        IDEX_Flush = 1'b1;
                    end else if (ID_MulDiv) begin
                        MulDiv_Start = 1'b1;
                        PC_We        = 1'b0;
                        IFID_We      = 1'b0;
                        IDEX_Flush   = 1'b1;
                    end
                end
                MDBUSY: begin
                    MulDiv_Busy = 1'b1;
                    if (cnt_reg != '0) begin
                        PC_We      = 1'b0;
                        IFID_We    = 1'b0;
                        IDEX_Flush = 1'b1;
                    end else begin
                        MulDiv_Done = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt_reg <= '0;
        end else if (!PC_We && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign Stall_Cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed, table-driven bench for hazard_stall_ctrl (MD_LAT = 8).
module tb_hazard_stall_ctrl;

    localparam int MD_LAT = 8;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        MemR_EX;
    logic [4:0]  EX_rfWeSel;
    logic [4:0]  ID_rfReSel1;
    logic [4:0]  ID_rfReSel2;
    logic        ID_useRs;
    logic        ID_useRt;
    logic        ID_MulDiv;
    logic        Branch_EX;
    logic        PC_We;
    logic        IFID_We;
    logic        IFID_Flush;
    logic        IDEX_Flush;
    logic        MulDiv_Start;
    logic        MulDiv_Busy;
    logic        MulDiv_Done;
    logic [15:0] Stall_Cnt;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_stall_ctrl #(.MD_LAT(MD_LAT)) dut (
        .Clk(Clk), .Reset(Reset), .MemR_EX(MemR_EX), .EX_rfWeSel(EX_rfWeSel),
        .ID_rfReSel1(ID_rfReSel1), .ID_rfReSel2(ID_rfReSel2),
        .ID_useRs(ID_useRs), .ID_useRt(ID_useRt), .ID_MulDiv(ID_MulDiv),
        .Branch_EX(Branch_EX), .PC_We(PC_We), .IFID_We(IFID_We),
        .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
        .MulDiv_Start(MulDiv_Start), .MulDiv_Busy(MulDiv_Busy),
        .MulDiv_Done(MulDiv_Done), .Stall_Cnt(Stall_Cnt)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       memr;
        logic [4:0] ex_sel;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use_rs;
        logic       use_rt;
        logic       muldiv;
        logic       branch;
        logic       e_pc_we;
        logic       e_ifid_we;
        logic       e_ifid_fl;
        logic       e_idex_fl;
        logic       e_start;
        logic       e_busy_next;
        logic [15:0] e_stall_next;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: act=%0d req=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemR_EX = 0; EX_rfWeSel = 0; ID_rfReSel1 = 0; ID_rfReSel2 = 0;
        ID_useRs = 0; ID_useRt = 0; ID_MulDiv = 0; Branch_EX = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 1;
        tick();
        Reset = 0;
    endtask

    task automatic chk_defaults(input string nm);
        chk({nm, ".pc_we"}, PC_We, 1);
        chk({nm, ".ifid_we"}, IFID_We, 1);
        chk({nm, ".ifid_fl"}, IFID_Flush, 0);
        chk({nm, ".idex_fl"}, IDEX_Flush, 0);
        chk({nm, ".start"}, MulDiv_Start, 0);
        chk({nm, ".busy"}, MulDiv_Busy, 0);
        chk({nm, ".done"}, MulDiv_Done, 0);
    endtask

    // Launch a mult/div now and follow it to IDLE, with stray hazards injected while busy.
    task automatic md_seq(input string nm, input int stall_base);
        ID_MulDiv = 1;
        #1;
        chk({nm, ".T.start"}, MulDiv_Start, 1);
        chk({nm, ".T.pc_we"}, PC_We, 0);
        chk({nm, ".T.busy"}, MulDiv_Busy, 0);
        chk({nm, ".T.done"}, MulDiv_Done, 0);
        for (int k = 1; k <= MD_LAT; k++) begin
            tick();
            Branch_EX = k[0];
            MemR_EX = 1; EX_rfWeSel = 3; ID_rfReSel1 = 3; ID_useRs = 1;
            #1;
            chk($sformatf("%s.T+%0d.busy", nm, k), MulDiv_Busy, 1);
            chk($sformatf("%s.T+%0d.done", nm, k), MulDiv_Done, (k == MD_LAT) ? 1 : 0);
            chk($sformatf("%s.T+%0d.pc_we", nm, k), PC_We, (k == MD_LAT) ? 1 : 0);
            chk($sformatf("%s.T+%0d.idex_fl", nm, k), IDEX_Flush, (k == MD_LAT) ? 0 : 1);
            chk($sformatf("%s.T+%0d.ifid_fl", nm, k), IFID_Flush, 0);
            chk($sformatf("%s.T+%0d.start", nm, k), MulDiv_Start, 0);
        end
        tick();
        idle_inputs();
        #1;
        chk({nm, ".end.busy"}, MulDiv_Busy, 0);
        chk({nm, ".end.stall_cnt"}, Stall_Cnt, stall_base + MD_LAT);
        $display("md_seq %s checked, Stall_Cnt=%0d", nm, Stall_Cnt);
    endtask

    initial begin
        //          memr ex rs1 rs2 urs urt md  br  pc ifw iff idf st bn  stall
        vecs[0]  = '{0,   0, 0,  0,  0,  0,  0,  0,  1, 1,  0,  0,  0, 0, 16'd0};
        vecs[1]  = '{1,   5, 0,  5,  0,  1,  0,  0,  0, 0,  0,  1,  0, 0, 16'd1};
        vecs[2]  = '{1,   0, 0,  0,  0,  1,  0,  0,  1, 1,  0,  0,  0, 0, 16'd0};
        vecs[3]  = '{1,   5, 0,  5,  0,  0,  0,  0,  1, 1,  0,  0,  0, 0, 16'd0};
        vecs[4]  = '{1,   7, 7,  0,  1,  0,  0,  0,  0, 0,  0,  1,  0, 0, 16'd1};
        vecs[5]  = '{0,   7, 7,  0,  1,  0,  0,  0,  1, 1,  0,  0,  0, 0, 16'd0};
        vecs[6]  = '{0,   0, 0,  0,  0,  0,  0,  1,  1, 1,  1,  1,  0, 0, 16'd0};
        vecs[7]  = '{1,   5, 0,  5,  0,  1,  1,  1,  1, 1,  1,  1,  0, 0, 16'd0};
        vecs[8]  = '{1,   5, 0,  5,  0,  1,  1,  0,  0, 0,  0,  1,  0, 0, 16'd1};
        vecs[9]  = '{0,   0, 0,  0,  0,  0,  1,  0,  0, 0,  0,  1,  1, 1, 16'd1};
        vecs[10] = '{1,   9, 4,  9,  1,  0,  0,  0,  1, 1,  0,  0,  0, 0, 16'd0};

        idle_inputs();
        Reset = 1;

        // Reset with random inputs: every output at default, counter cleared.
        for (int c = 0; c < 2; c++) begin
            tick();
            MemR_EX = 1'($urandom); EX_rfWeSel = 5'($urandom);
            ID_rfReSel1 = 5'($urandom); ID_rfReSel2 = 5'($urandom);
            ID_useRs = 1'($urandom); ID_useRt = 1'($urandom);
            ID_MulDiv = 1; Branch_EX = 1'($urandom);
            #1;
            chk_defaults($sformatf("reset%0d", c));
        end
        tick();
        Reset = 0;
        idle_inputs();
        #1;
        chk("reset.stall_cnt", Stall_Cnt, 0);
        tick();
        #1;
        chk("reset.release.stall_cnt", Stall_Cnt, 0);
        $display("reset checked");

        // Single-cycle vectors, each from a clean reset.
        for (int v = 0; v < 11; v++) begin
            do_reset();
            MemR_EX = vecs[v].memr; EX_rfWeSel = vecs[v].ex_sel;
            ID_rfReSel1 = vecs[v].rs1; ID_rfReSel2 = vecs[v].rs2;
            ID_useRs = vecs[v].use_rs; ID_useRt = vecs[v].use_rt;
            ID_MulDiv = vecs[v].muldiv; Branch_EX = vecs[v].branch;
            #1;
            chk($sformatf("vec%0d.pc_we", v), PC_We, vecs[v].e_pc_we);
            chk($sformatf("vec%0d.ifid_we", v), IFID_We, vecs[v].e_ifid_we);
            chk($sformatf("vec%0d.ifid_fl", v), IFID_Flush, vecs[v].e_ifid_fl);
            chk($sformatf("vec%0d.idex_fl", v), IDEX_Flush, vecs[v].e_idex_fl);
            chk($sformatf("vec%0d.start", v), MulDiv_Start, vecs[v].e_start);
            chk($sformatf("vec%0d.busy", v), MulDiv_Busy, 0);
            chk($sformatf("vec%0d.done", v), MulDiv_Done, 0);
            tick();
            idle_inputs();
            #1;
            chk($sformatf("vec%0d.busy_next", v), MulDiv_Busy, vecs[v].e_busy_next);
            chk($sformatf("vec%0d.stall_cnt", v), Stall_Cnt, vecs[v].e_stall_next);
            $display("vec %0d applied: PC_We=%0b IDEX_Flush=%0b Stall_Cnt=%0d",
                     v, vecs[v].e_pc_we, vecs[v].e_idex_fl, Stall_Cnt);
        end

        // Full mult/div sequence.
        do_reset();
        md_seq("md", 0);

        // Back-to-back: a second one may enter on the cycle after Done.
        do_reset();
        md_seq("b2b_first", 0);
        md_seq("b2b_second", MD_LAT);

        // Reset in the middle of a mult/div.
        do_reset();
        ID_MulDiv = 1;
        tick();
        tick();
        tick();
        Reset = 1;
        #1;
        chk_defaults("midrst.T+3");
        tick();
        Reset = 0;
        ID_MulDiv = 0;
        #1;
        chk("midrst.T+4.busy", MulDiv_Busy, 0);
        chk("midrst.T+4.done", MulDiv_Done, 0);
        chk("midrst.T+4.pc_we", PC_We, 1);
        chk("midrst.T+4.stall_cnt", Stall_Cnt, 0);
        tick();
        md_seq("midrst.after", 0);

        // Saturation: continuous mult/div gives 8 stalls per 9 cycles.
        do_reset();
        ID_MulDiv = 1;
        repeat (9 * 8191) @(posedge Clk);
        #2;
        chk("sat.pre", Stall_Cnt, 65528);
        repeat (9) @(posedge Clk);
        #2;
        chk("sat.hit", Stall_Cnt, 65535);
        repeat (9) @(posedge Clk);
        #2;
        chk("sat.hold", Stall_Cnt, 65535);
        $display("saturation checked, Stall_Cnt=%0d", Stall_Cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline stall/flush sequencer for the 5-stage CPU, sitting alongside the forwarding unit. It generates PC and IF/ID write-enables and IF/ID and ID/EX flushes for three cases: load-use hazards, taken branches resolved in EX, and multi-cycle multiply/divide operations. For mult/div it runs a busy state machine that holds the instruction in ID for a fixed latency. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- MD_LAT, 8, mult/div latency in cycles; legal range 2..32. Counter width is $clog2(MD_LAT).

Ports:
- Clk  in  1  pipeline clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- MemR_EX  in  1  instruction in EX is a load.
- EX_rfWeSel  in  5  destination register of the instruction in EX.
- ID_rfReSel1  in  5  rs of the instruction in ID.
- ID_rfReSel2  in  5  rt of the instruction in ID.
- ID_useRs, ID_useRt  in  1 each  instruction in ID actually reads rs / rt.
- ID_MulDiv  in  1  instruction in ID is mult/div.
- Branch_EX  in  1  branch/jump in EX resolved taken this cycle.
- PC_We  out  1  PC write enable.
- IFID_We  out  1  IF/ID register write enable.
- IFID_Flush  out  1  zero the IF/ID register at the next edge.
- IDEX_Flush  out  1  insert a bubble into ID/EX at the next edge.
- MulDiv_Start  out  1  one-cycle pulse that launches the mult/div unit.
- MulDiv_Busy  out  1  high while in MDBUSY.
- MulDiv_Done  out  1  one-cycle pulse on the final busy cycle.
- Stall_Cnt  out  16  saturating count of cycles with PC_We=0.

## Operation
- States: IDLE and MDBUSY. Additional registers: cnt and Stall_Cnt.
- Default outputs: PC_We=1, IFID_We=1, all flushes 0, all pulses 0.
- Hazard terms:
  - loaduse = MemR_EX && EX_rfWeSel!=0 && ((ID_useRs && EX_rfWeSel==ID_rfReSel1) || (ID_useRt && EX_rfWeSel==ID_rfReSel2)).
- IDLE, evaluated in strict priority:
  1. Branch_EX: IFID_Flush=1, IDEX_Flush=1. Stay in IDLE; the mult/div in ID is squashed and never started.
  2. loaduse: PC_We=0, IFID_We=0, IDEX_Flush=1 (one bubble). Stay in IDLE. The condition is re-evaluated next cycle.
  3. ID_MulDiv: MulDiv_Start=1, PC_We=0, IFID_We=0, IDEX_Flush=1. Load cnt=MD_LAT-1 and go to MDBUSY.
- MDBUSY: MulDiv_Busy=1. Branch_EX, loaduse and ID_MulDiv are ignored, since EX holds only bubbles.
  - cnt!=0: PC_We=0, IFID_We=0, IDEX_Flush=1, cnt decrements.
  - cnt==0: MulDiv_Done=1, stall released (default enables, no flush). Go to IDLE, so the mult/div advances to EX at this edge.
- Stall_Cnt: increments on every edge where Reset=0 and PC_We=0. It holds at 16'hFFFF and does not wrap.
- While Reset is high, all outputs are forced to their defaults. Reset at the edge sets state=IDLE, cnt=0, Stall_Cnt=0.

## Timing
- Reset values: PC_We=1, IFID_We=1, IFID_Flush=0, IDEX_Flush=0, MulDiv_Start=0, MulDiv_Busy=0, MulDiv_Done=0, Stall_Cnt=0.
- All control outputs are combinational from state plus inputs in the same cycle, with zero latency. Stall_Cnt is registered and lags by one cycle.
- Load-use costs exactly 1 stall cycle per occurrence.
- Mult/div entering at cycle T:
  - Start at T.
  - Busy during T+1..T+MD_LAT.
  - Done at T+MD_LAT.
  - PC_We=0 during T..T+MD_LAT-1, which is MD_LAT stall cycles.
  - IDLE at T+MD_LAT+1.
- Back-to-back mult/div: the second one enters at T+MD_LAT+1 at the earliest.
- Reset asserted during MDBUSY: next cycle is IDLE, no Done pulse, cnt cleared.
- Branch and loaduse in the same cycle: the flush wins and there is no stall.

## Test plan
- Reset: hold Reset 2 cycles with random inputs -> outputs at default values; Stall_Cnt=0 after release.
- Load-use: MemR_EX=1, EX_rfWeSel=5, ID_rfReSel2=5, ID_useRt=1 -> one cycle of PC_We=0, IFID_We=0, IDEX_Flush=1; Stall_Cnt=1. Same stimulus with EX_rfWeSel=0 or ID_useRt=0 -> no stall.
- Mult/div with MD_LAT=8: ID_MulDiv=1 at T -> Start at T; Busy at T+1..T+8; Done only at T+8; PC_We=0 for 8 cycles; Stall_Cnt=8.
- Priority: Branch_EX=1 together with loaduse=1 and ID_MulDiv=1 -> IFID_Flush=1, IDEX_Flush=1, PC_We=1, no Start; state stays IDLE.
- Reset mid-op: assert Reset at T+3 of a mult/div -> IDLE next cycle, no Done, Busy=0; a new ID_MulDiv then gives a full MD_LAT sequence.
- Saturation: force 70000 stall cycles with repeated mult/div -> Stall_Cnt stops at 65535 and does not wrap.
